// File: rtl/pipeline_pkg.sv
// Shared IF/ID pipeline types and constants.
// The bubble value is what decode sees whenever no real instruction is presented.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: 32'h0, pc_plus4: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/fetch_queue.sv
// FIFO between fetch and decode with flush on redirect.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue forward enq_data to decode in the same cycle.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  input  ifid_t                    enq_data,
  output logic                     enq_ready,
  output logic                     deq_valid,
  output ifid_t                    deq_data,
  input  logic                     deq_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  ifid_t          mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           full, empty, bypass, push, pop;

  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    enq_ready = !full && !flush && !reset;
    deq_valid = !empty && !flush && !reset;
    deq_data  = deq_valid ? mem_q[rd_ptr_q] : IFID_BUBBLE;
    bypass    = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (empty && enq_valid && !flush && !reset) begin
      bypass    = 1'b1;
      deq_valid = 1'b1;
      deq_data  = enq_data;
    end
`endif
    // A bypassed entry consumed by decode never touches storage.
    push = enq_valid && enq_ready && !(bypass && deq_ready);
    pop  = deq_valid && deq_ready && !bypass;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; outputs mask it with the bubble while deq_valid is low.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enq_data;
  end

  assign count = count_q;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of ifid_t entries; power of two, at least 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enq_valid  input  1  fetch stage presents a fetched instruction.
REQ-005 enq_data  input  ifid_t  fetched PC, PCPlus4, instr from the IF stage.
REQ-006 enq_ready  output  1  queue can accept an entry this cycle.
REQ-007 deq_valid  output  1  head entry available to decode.
REQ-008 deq_data  output  ifid_t  head entry presented to decode.
REQ-009 deq_ready  input  1  decode accepts the head entry (decode not stalled).
REQ-010 flush  input  1  redirect from a taken branch or jump; discard all queued entries.
REQ-011 count  output  $clog2(DEPTH)+1  number of valid entries held.

Function
REQ-012 Enqueue SHALL occur on a rising edge where enq_valid && enq_ready; dequeue SHALL occur where deq_valid && deq_ready.
REQ-013 Ordering SHALL be strict FIFO; entries leave in the order accepted.
REQ-014 enq_ready SHALL be !full && !flush && !reset; a full queue SHALL NOT accept, even when a dequeue happens in the same cycle.
REQ-015 deq_valid SHALL be (count != 0) && !flush && !reset, subject to REQ-024.
REQ-016 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-017 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL be derived from count.
REQ-018 Without bypass, latency from accepted enqueue to deq_valid SHALL be exactly 1 cycle.
REQ-019 While deq_valid is 0, deq_data SHALL be PC=0, PCPlus4=0, instr=NOP_INSTR (32'h00000013), so that decode sees a bubble.
REQ-020 When flush is high at a rising edge, count and both pointers SHALL become 0; any enqueue or dequeue in that cycle SHALL be ignored. Flush SHALL take priority over all other events.
REQ-021 Flush asserted on consecutive cycles SHALL hold the queue empty; normal operation SHALL resume on the first cycle after flush is released.

Reset
REQ-022 On a rising edge with reset high: count, read pointer and write pointer SHALL become 0. While reset is high, enq_ready=0, deq_valid=0 and deq_data SHALL be the bubble from REQ-019. Reset SHALL override flush, and resetting mid-operation SHALL discard all entries.
REQ-023 Storage array contents SHALL NOT require reset; no output may depend on unreset storage while deq_valid is 0.

Configuration
REQ-024 With macro FETCH_QUEUE_BYPASS_EN defined: when count==0 and enq_valid is high (no flush, no reset), deq_valid=1 and deq_data=enq_data in the same cycle. If deq_ready is also high, the entry SHALL NOT be written and count SHALL stay 0. Without the macro: no combinational path from enq_* to deq_* exists, and REQ-018 applies.

Structure
REQ-025 ifid_t SHALL remain in pipeline_pkg; the constant NOP_INSTR (32'h00000013) SHALL be added to pipeline_pkg.
REQ-026 No sub-module SHALL be used: storage is a DEPTH-entry ifid_t register array inside fetch_queue, with no memory macro.

Verification
REQ-027 Reset, then enqueue PC=0x00,0x04,0x08 on 3 consecutive cycles with deq_ready=0 -> count=3. Then deq_ready=1 -> deq_data.PC = 0x00, 0x04, 0x08 in order, then deq_valid=0 and instr=0x00000013.
REQ-028 DEPTH=4: fill with 4 entries -> enq_ready=0 and count=4. Assert enq_valid plus deq_ready -> one dequeue, no enqueue, count=3.
REQ-029 Continuous enq and deq for 10 cycles, count held at 2 -> pointers wrap twice, PCs 0x00..0x24 emerge in order, count stays 2.
REQ-030 count=3, assert flush with enq_valid=1 and deq_ready=1 -> next cycle count=0, deq_valid=0; the flush-cycle entry is never output.
REQ-031 Assert reset with count=2 and flush=1 -> next cycle count=0, enq_ready=1 after reset drops.
REQ-032 With FETCH_QUEUE_BYPASS_EN, empty queue, enq_valid=1 PC=0x40, deq_ready=1 -> deq_valid=1, deq_data.PC=0x40 in the same cycle, count stays 0. Without the macro -> deq_valid=0 that cycle, 1 the next.
